// File: rtl/neuralnet_pkg.sv
// rtl/neuralnet_pkg.sv - image geometry, link constants and readback FSM states
package neuralnet_pkg;

    localparam int HEIGHT     = 20;
    localparam int WIDTH      = 30;
    localparam int DEPTH      = 3;
    localparam int IMG_BYTES  = HEIGHT * WIDTH * DEPTH;
    localparam int IMG_ADDR_W = $clog2(IMG_BYTES);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_FETCH    = 3'd2,
        ST_LOAD     = 3'd3,
        ST_DATA     = 3'd4,
        ST_CSUM     = 3'd5,
        ST_WAIT_LOW = 3'd6
    } tx_state_t;

endpackage

// File: rtl/image_readback_tx.sv
// rtl/image_readback_tx.sv - streams the image buffer to the Pi as sync, data bytes and checksum
module image_readback_tx
    import neuralnet_pkg::*;
(
    input  logic                  pi_clk,
    input  logic                  rst,
    input  logic                  read_enable,
    input  logic                  byte_ack,
    output logic                  mem_rd,
    output logic [IMG_ADDR_W-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            gpio_out,
    output logic                  gpio_valid,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IMG_ADDR_W-1:0] LAST_IDX = IMG_ADDR_W'(IMG_BYTES - 1);

    tx_state_t             state_q, state_d;
    logic [IMG_ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            gpio_out_q, gpio_out_d;
    logic                  gpio_valid_q, gpio_valid_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [IMG_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack;
    logic                  active;

    // An ack only counts while a byte is actually on offer.
    assign ack    = byte_ack && gpio_valid_q;
    assign active = (state_q == ST_HEADER) || (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        gpio_out_d   = gpio_out_q;
        gpio_valid_d = gpio_valid_q;
        mem_rd_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gpio_valid_d = 1'b0;
                if (read_enable) begin
                    state_d      = ST_HEADER;
                    idx_d        = '0;
                    sum_d        = '0;
                    gpio_out_d   = SYNC_BYTE;
                    gpio_valid_d = 1'b1;
                end
            end
            ST_HEADER: begin
                if (ack) begin
                    state_d      = ST_FETCH;
                    gpio_valid_d = 1'b0;
                    mem_rd_d     = 1'b1;
                    mem_addr_d   = idx_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d      = ST_DATA;
                gpio_out_d   = mem_rdata;
                sum_d        = sum_q + mem_rdata;
                gpio_valid_d = 1'b1;
            end
            ST_DATA: begin
                if (ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_CSUM;
                        gpio_out_d = sum_q;
                    end else begin
                        state_d      = ST_FETCH;
                        idx_d        = idx_q + 1'b1;
                        mem_rd_d     = 1'b1;
                        mem_addr_d   = idx_q + 1'b1;
                        gpio_valid_d = 1'b0;
                    end
                end
            end
            ST_CSUM: begin
                if (ack) begin
                    state_d      = ST_WAIT_LOW;
                    gpio_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                gpio_valid_d = 1'b0;
                if (!read_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                gpio_valid_d = 1'b0;
            end
        endcase

        // Dropping read_enable mid-frame wins over any ack seen in the same cycle.
        if (active && !read_enable) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            sum_d        = '0;
            gpio_out_d   = gpio_out_q;
            gpio_valid_d = 1'b0;
            mem_rd_d     = 1'b0;
            mem_addr_d   = mem_addr_q;
            done_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT_LOW);
    end

    always_ff @(posedge pi_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sum_q        <= '0;
            gpio_out_q   <= '0;
            gpio_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            gpio_out_q   <= gpio_out_d;
            gpio_valid_q <= gpio_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign gpio_out   = gpio_out_q;
    assign gpio_valid = gpio_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_image_readback_tx.sv
// tb/tb_image_readback_tx.sv - directed self-checking bench for image_readback_tx
module tb_image_readback_tx;
    import neuralnet_pkg::*;

    logic                  pi_clk = 1'b0;
    logic                  rst;
    logic                  read_enable;
    logic                  byte_ack;
    logic                  mem_rd;
    logic [IMG_ADDR_W-1:0] mem_addr;
    logic [7:0]            mem_rdata;
    logic [7:0]            gpio_out;
    logic                  gpio_valid;
    logic                  busy;
    logic                  done;

    logic [7:0] mem [0:IMG_BYTES-1];
    logic [7:0] rx [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc;
    int         done_cnt;
    int         done_cyc;
    bit         unstable;
    bit         oob = 1'b0;

    image_readback_tx dut (
        .pi_clk      (pi_clk),
        .rst         (rst),
        .read_enable (read_enable),
        .byte_ack    (byte_ack),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .gpio_out    (gpio_out),
        .gpio_valid  (gpio_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 pi_clk = ~pi_clk;

    always @(posedge pi_clk) begin
        cyc <= cyc + 1;
        if (mem_rd) begin
            if (int'(mem_addr) >= IMG_BYTES) oob <= 1'b1;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // max_delay < 0 holds byte_ack high throughout; stop_at returns when that many bytes are taken
    task automatic run_frame(input int max_delay, input bit spurious, input int stop_at);
        int         delay;
        bit         have;
        logic [7:0] held;
        rx.delete();
        done_cnt    = 0;
        done_cyc    = 0;
        unstable    = 1'b0;
        have        = 1'b0;
        delay       = 0;
        held        = '0;
        read_enable = 1'b1;
        start_cyc   = cyc;
        for (int n = 0; n < 30000; n++) begin
            @(negedge pi_clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
                byte_ack = 1'b0;
                return;
            end
            if (gpio_valid && rx.size() == stop_at) return;
            if (max_delay < 0) begin
                byte_ack = 1'b1;
                if (gpio_valid) rx.push_back(gpio_out);
            end else begin
                byte_ack = 1'b0;
                if (gpio_valid) begin
                    if (!have) begin
                        have  = 1'b1;
                        held  = gpio_out;
                        delay = int'($urandom_range(0, max_delay));
                    end else if (gpio_out !== held) begin
                        unstable = 1'b1;
                    end
                    if (delay == 0) begin
                        byte_ack = 1'b1;
                        rx.push_back(gpio_out);
                        have = 1'b0;
                    end else begin
                        delay--;
                    end
                end else begin
                    have = 1'b0;
                    if (spurious) byte_ack = 1'($urandom_range(0, 1));
                end
            end
        end
        check("frame_timeout", 32'd0, 32'd1);
    endtask

    function automatic int ramp_bad();
        int bad = 0;
        for (int i = 0; i < IMG_BYTES; i++)
            if (i + 1 >= rx.size() || rx[i+1] !== 8'(i % 256)) bad++;
        return bad;
    endfunction

    initial begin
        int cnt;
        rst         = 1'b1;
        read_enable = 1'b1;
        byte_ack    = 1'b0;
        for (int i = 0; i < IMG_BYTES; i++) mem[i] = 8'(i % 256);

        for (int k = 0; k < 2; k++) begin
            @(negedge pi_clk);
            check("rst_gpio_out", 32'(gpio_out), 32'h0);
            check("rst_valid", 32'(gpio_valid), 32'h0);
            check("rst_mem_rd", 32'(mem_rd), 32'h0);
            check("rst_mem_addr", 32'(mem_addr), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_done", 32'(done), 32'h0);
        end
        rst = 1'b0;
        @(negedge pi_clk);
        check("hdr_valid", 32'(gpio_valid), 32'h1);
        check("hdr_byte", 32'(gpio_out), 32'hA5);
        check("hdr_busy", 32'(busy), 32'h1);
        read_enable = 1'b0;
        @(negedge pi_clk);
        check("hdr_abort_valid", 32'(gpio_valid), 32'h0);
        check("hdr_abort_busy", 32'(busy), 32'h0);

        // Ramp data, ack held high
        run_frame(-1, 1'b0, -1);
        check("ramp_len", 32'(rx.size()), 32'd1802);
        check("ramp_hdr", 32'(rx[0]), 32'hA5);
        check("ramp_data_bad", 32'(ramp_bad()), 32'd0);
        check("ramp_csum", 32'(rx[1801]), 32'h9C);
        check("ramp_done_cnt", 32'(done_cnt), 32'd1);
        check("ramp_done_cyc", 32'(done_cyc), 32'd5403);
        @(negedge pi_clk);
        check("ramp_done_pulse", 32'(done), 32'h0);
        check("ramp_wait_valid", 32'(gpio_valid), 32'h0);
        check("ramp_wait_busy", 32'(busy), 32'h0);
        read_enable = 1'b0;
        @(negedge pi_clk);

        // Constant 02 data, random ack delays, spurious acks between bytes
        for (int i = 0; i < IMG_BYTES; i++) mem[i] = 8'h02;
        run_frame(5, 1'b1, -1);
        cnt = 0;
        for (int i = 1; i <= IMG_BYTES && i < rx.size(); i++) if (rx[i] !== 8'h02) cnt++;
        check("c02_len", 32'(rx.size()), 32'd1802);
        check("c02_hdr", 32'(rx[0]), 32'hA5);
        check("c02_data_bad", 32'(cnt), 32'd0);
        check("c02_csum", 32'(rx[1801]), 32'h10);
        check("c02_stable", 32'(unstable), 32'h0);
        check("c02_done_cnt", 32'(done_cnt), 32'd1);
        read_enable = 1'b0;
        @(negedge pi_clk);

        // Abort at data index 100 with a simultaneous ack
        for (int i = 0; i < IMG_BYTES; i++) mem[i] = 8'(i % 256);
        run_frame(-1, 1'b0, 101);
        check("abort_byte", 32'(gpio_out), 32'h64);
        read_enable = 1'b0;
        byte_ack    = 1'b1;
        @(negedge pi_clk);
        check("abort_valid", 32'(gpio_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        cnt = 32'(done);
        for (int k = 0; k < 5; k++) begin
            @(negedge pi_clk);
            cnt += 32'(done) + 32'(gpio_valid);
        end
        check("abort_quiet", 32'(cnt), 32'd0);
        byte_ack = 1'b0;
        run_frame(-1, 1'b0, -1);
        check("rearm_len", 32'(rx.size()), 32'd1802);
        check("rearm_hdr", 32'(rx[0]), 32'hA5);
        check("rearm_first", 32'(rx[1]), 32'h00);
        check("rearm_data_bad", 32'(ramp_bad()), 32'd0);
        check("rearm_csum", 32'(rx[1801]), 32'h9C);
        check("rearm_done_cyc", 32'(done_cyc), 32'd5403);
        read_enable = 1'b0;
        @(negedge pi_clk);

        // Reset while the checksum byte is on offer
        run_frame(-1, 1'b0, 1801);
        check("csum_before_rst", 32'(gpio_out), 32'h9C);
        rst      = 1'b1;
        byte_ack = 1'b0;
        @(negedge pi_clk);
        check("mrst_gpio_out", 32'(gpio_out), 32'h0);
        check("mrst_valid", 32'(gpio_valid), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_mem_addr", 32'(mem_addr), 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        rst = 1'b0;
        run_frame(-1, 1'b0, -1);
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_csum", 32'(rx[1801]), 32'h9C);
        byte_ack = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge pi_clk);
            cnt += 32'(gpio_valid) + 32'(busy) + 32'(done);
        end
        check("no_auto_repeat", 32'(cnt), 32'd0);
        byte_ack    = 1'b0;
        read_enable = 1'b0;
        @(negedge pi_clk);
        @(negedge pi_clk);
        read_enable = 1'b1;
        @(negedge pi_clk);
        check("toggle_hdr_valid", 32'(gpio_valid), 32'h1);
        check("toggle_hdr_byte", 32'(gpio_out), 32'hA5);
        read_enable = 1'b0;
        @(negedge pi_clk);

        check("mem_in_range", 32'(oob), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
